wb_b3_classic_bridge: RTL and testbench
=======================================

Name: wb_b3_classic_bridge

Overview:
Registered Wishbone B3 bridge between the SoC external bus master port (wb_ext_*) and a classic-cycle memory or peripheral slave. Each master beat, including every beat of a B3 burst, becomes one registered classic single access on the slave side. This breaks the combinational path from slave to master. A per-access watchdog answers with err when the slave never acknowledges, so a dead slave cannot hang the CPU.

Parameters:
AW, 32, address width on both sides
DW, 32, data width; sel width is DW/8
TIMEOUT, 255, max ACCESS cycles before forced err; 0 disables the watchdog
TW, $clog2(TIMEOUT+1), watchdog counter width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m_adr_i  in  AW  master address
m_dat_i  in  DW  master write data
m_sel_i  in  DW/8  byte selects
m_we_i  in  1  write enable
m_cyc_i  in  1  master cycle
m_stb_i  in  1  master strobe
m_cti_i  in  3  cycle type; accepted, not forwarded
m_bte_i  in  2  burst type; accepted, not forwarded
m_dat_o  out  DW  read data to master
m_ack_o  out  1  beat acknowledge
m_err_o  out  1  beat error (slave err or timeout)
m_rty_o  out  1  tied 0
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave byte selects
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave acknowledge
s_err_i  in  1  slave error
timeout_o  out  1  one-cycle pulse on watchdog expiry
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: all outputs and registers are 0, and state is IDLE. Assertion takes effect immediately, including mid-access: s_cyc_o/s_stb_o drop with no master ack.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On m_cyc_i & m_stb_i, latch m_adr_i/m_dat_i/m_sel_i/m_we_i into s_adr_o/s_dat_o/s_sel_o/s_we_o.
  - Set s_cyc_o = s_stb_o = 1, clear the watchdog counter, and go to ACCESS.
- ACCESS, evaluated each edge in priority order:
  1. m_cyc_i = 0 (abort): s_cyc_o/s_stb_o go to 0 and the FSM returns to IDLE. No ack or err is issued.
  2. s_err_i = 1: this also wins when s_err_i and s_ack_i are high together. Drop s_cyc/stb, set m_err_o, go to RESP.
  3. s_ack_i = 1: capture s_dat_i into m_dat_o (on reads and writes), drop s_cyc/stb, set m_ack_o, go to RESP.
  4. TIMEOUT != 0 and counter == TIMEOUT-1: drop s_cyc/stb, set m_err_o and timeout_o, go to RESP. An ack arriving on the expiry cycle wins under rule 3.
  5. Otherwise, counter += 1. The counter saturates and never wraps.
- RESP: m_ack_o or m_err_o is high for exactly this one cycle, then cleared, and the FSM returns to IDLE. m_stb_i seen during RESP belongs to the beat being acked and is ignored.
- Latency:
  - Master stb is sampled at edge 1, so s_stb_o is high in cycle 1.
  - A slave ack in cycle k gives m_ack_o in cycle k+1.
  - Minimum is 2 cycles from stb to ack; peak throughput is 1 beat per 3 cycles.
- Bursts: cti/bte are ignored. Each beat uses the address the master presents for that beat. Because acks are never early, beat counts match exactly, and the end-of-burst beat (cti 111) is handled like any other.
- m_dat_o holds its last captured value until the next ack capture.
- s_cyc_o and s_stb_o are always equal.
- Outputs are registered only; there are no combinational paths from slave inputs to master outputs.

Test Plan:
1. Read: m_adr_i=0x100, we=0. Slave acks in cycle 1 with s_dat_i=0xDEADBEEF. Expect s_adr_o=0x100 in cycle 1, m_ack_o=1 only in cycle 2, m_dat_o=0xDEADBEEF.
2. Write: adr=0x2000, dat=0xA5A5_1234, sel=0x3. Slave acks after 4 wait cycles. Expect s_stb_o high for exactly 5 cycles, s_dat_o/s_sel_o/s_we_o stable throughout, and one m_ack_o pulse.
3. Timeout with TIMEOUT=8: slave silent. Expect s_stb_o high in cycles 1-8, m_err_o=1 and timeout_o=1 in cycle 9, busy_o=0 in cycle 10. Repeat with ack in cycle 8: expect m_ack_o, no timeout_o.
4. Slave asserts s_ack_i and s_err_i in the same cycle. Expect m_err_o=1, m_ack_o=0, m_dat_o unchanged.
5. Incrementing burst: cti=010, bte=00, 4 beats from 0x40. Expect 4 slave cycles at 0x40/0x44/0x48/0x4C, 4 m_ack_o pulses, last beat cti=111, and a return to IDLE.
6. Aborts:
   - Master drops m_cyc_i during ACCESS: expect s_cyc_o=0 next edge, no ack.
   - rst_n pulsed low mid-access: expect all outputs 0 asynchronously; the next access proceeds normally.

Source files
------------

// File: rtl/wb_b3_classic_bridge.sv
// Registered Wishbone B3 master-port to classic-cycle slave bridge.
// Each master beat becomes one registered single access, guarded by a per-access watchdog.
module wb_b3_classic_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   m_adr_i,
  input  logic [DW-1:0]   m_dat_i,
  input  logic [DW/8-1:0] m_sel_i,
  input  logic            m_we_i,
  input  logic            m_cyc_i,
  input  logic            m_stb_i,
  input  logic [2:0]      m_cti_i,
  input  logic [1:0]      m_bte_i,
  output logic [DW-1:0]   m_dat_o,
  output logic            m_ack_o,
  output logic            m_err_o,
  output logic            m_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic            timeout_o,
  output logic            busy_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = (TW < 1) ? 1 : TW;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   s_adr_d;
  logic [DW-1:0]   s_dat_d, m_dat_d;
  logic [SW-1:0]   s_sel_d;
  logic            s_we_d, s_cyc_d, m_ack_d, m_err_d, timeout_d, busy_d;

  // Burst qualifiers are accepted but every beat is handled as a single access.
  logic unused_burst_c;
  assign unused_burst_c = ^{m_cti_i, m_bte_i};

  assign m_rty_o = 1'b0;
  assign s_stb_o = s_cyc_o;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      s_sel_o   <= '0;
      s_we_o    <= 1'b0;
      s_cyc_o   <= 1'b0;
      m_dat_o   <= '0;
      m_ack_o   <= 1'b0;
      m_err_o   <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_adr_o   <= s_adr_d;
      s_dat_o   <= s_dat_d;
      s_sel_o   <= s_sel_d;
      s_we_o    <= s_we_d;
      s_cyc_o   <= s_cyc_d;
      m_dat_o   <= m_dat_d;
      m_ack_o   <= m_ack_d;
      m_err_o   <= m_err_d;
      timeout_o <= timeout_d;
      busy_o    <= busy_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_adr_d   = s_adr_o;
    s_dat_d   = s_dat_o;
    s_sel_d   = s_sel_o;
    s_we_d    = s_we_o;
    s_cyc_d   = s_cyc_o;
    m_dat_d   = m_dat_o;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          s_adr_d = m_adr_i;
          s_dat_d = m_dat_i;
          s_sel_d = m_sel_i;
          s_we_d  = m_we_i;
          s_cyc_d = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!m_cyc_i) begin
          s_cyc_d = 1'b0;
          state_d = IDLE;
        end else if (s_err_i) begin
          s_cyc_d = 1'b0;
          m_err_d = 1'b1;
          state_d = RESP;
        end else if (s_ack_i) begin
          m_dat_d = s_dat_i;
          s_cyc_d = 1'b0;
          m_ack_d = 1'b1;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          s_cyc_d   = 1'b0;
          m_err_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        // Strobe seen here belongs to the beat being answered.
        state_d = IDLE;
      end
      default: begin
        s_cyc_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_wb_b3_classic_bridge.sv
// Directed, table-driven bench for wb_b3_classic_bridge with a cycle-accurate slave responder.
module tb_wb_b3_classic_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_sel;
  logic          m_we, m_cyc, m_stb;
  logic [2:0]    m_cti;
  logic [1:0]    m_bte;
  logic [DW-1:0] m_dat_o;
  logic          m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;
  logic          timeout_o, busy_o;

  wb_b3_classic_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .timeout_o(timeout_o), .busy_o(busy_o)
  );

  // dly: cycle (counted from the first s_stb_o cycle) in which the slave responds; 0 = never.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    int          dly;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    int          exp_stb;
    logic        exp_ack;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_mdat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one master beat, plays the slave, and checks the full beat timeline.
  task automatic run_beat(input vec_t v, input bit keep_cyc, input string tag);
    int c;
    int stb_n;
    bit stable;
    m_cyc = 1'b1; m_stb = 1'b1;
    m_adr = v.adr; m_dat = v.dat; m_sel = v.sel; m_we = v.we; m_cti = v.cti;
    @(posedge clk); #1;
    c = 1; stb_n = 0; stable = 1'b1;
    chk({tag, " s_adr_cycle1"}, 64'(s_adr_o), 64'(v.adr));
    while (s_cyc_o === 1'b1 && c < 40) begin
      stb_n++;
      if (s_stb_o !== 1'b1 || s_adr_o !== v.adr || s_dat_o !== v.dat || s_sel_o !== v.sel ||
          s_we_o !== v.we || m_ack_o !== 1'b0 || m_err_o !== 1'b0 || busy_o !== 1'b1)
        stable = 1'b0;
      if (c == v.dly) begin
        s_ack = v.ack; s_err = v.err; s_dat = v.rdat;
      end else begin
        s_ack = 1'b0; s_err = 1'b0; s_dat = 32'h0BAD_0BAD;
      end
      @(posedge clk); #1;
      c++;
    end
    s_ack = 1'b0; s_err = 1'b0;
    chk({tag, " stb_cycles"}, 64'(stb_n), 64'(v.exp_stb));
    chk({tag, " slave_side_stable"}, 64'(stable), 64'd1);
    chk({tag, " m_ack"}, 64'(m_ack_o), 64'(v.exp_ack));
    chk({tag, " m_err"}, 64'(m_err_o), 64'(v.exp_err));
    chk({tag, " timeout"}, 64'(timeout_o), 64'(v.exp_to));
    chk({tag, " m_dat"}, 64'(m_dat_o), 64'(v.exp_mdat));
    chk({tag, " s_cyc_resp"}, 64'(s_cyc_o), 64'd0);
    if (!keep_cyc) begin
      m_cyc = 1'b0; m_stb = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, " ack_cleared"}, 64'({m_ack_o, m_err_o, timeout_o}), 64'd0);
    chk({tag, " idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  vec_t vecs[7];
  vec_t b;

  initial begin
    rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    m_cti = 3'b000; m_bte = 2'b00;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;

    //            we    adr           dat           sel   cti   dly ack   err   rdat          stb ack   err   to    mdat
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,        4'hF, 3'd0, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_2000, 32'hA5A5_1234, 4'h3, 3'd0, 5, 1'b1, 1'b0, 32'h1111_2222, 5, 1'b1, 1'b0, 1'b0, 32'h1111_2222};
    vecs[2] = '{1'b0, 32'h0000_0300, 32'h0,        4'hF, 3'd0, 0, 1'b0, 1'b0, 32'h0,         8, 1'b0, 1'b1, 1'b1, 32'h1111_2222};
    vecs[3] = '{1'b0, 32'h0000_0304, 32'h0,        4'hF, 3'd0, 8, 1'b1, 1'b0, 32'hCAFE_F00D, 8, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 32'h0000_0308, 32'h0,        4'hF, 3'd0, 2, 1'b1, 1'b1, 32'h5555_5555, 2, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'h0000_030C, 32'h7777_8888, 4'hC, 3'd0, 3, 1'b0, 1'b1, 32'h6666_6666, 3, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        4'h1, 3'd0, 7, 1'b1, 1'b0, 32'h8000_0001, 7, 1'b1, 1'b0, 1'b0, 32'h8000_0001};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o, s_we_o, timeout_o, busy_o}), 64'd0);
    chk("reset_data", 64'({m_dat_o, s_adr_o}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_request", 64'({s_cyc_o, busy_o}), 64'd0);

    for (int i = 0; i < 7; i++) run_beat(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Incrementing burst, cyc held across beats, last beat marked end-of-burst.
    for (int i = 0; i < 4; i++) begin
      b = '{1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF, (i == 3) ? 3'b111 : 3'b010, 1, 1'b1, 1'b0,
            32'h1000 + 32'(i), 1, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i)};
      run_beat(b, (i != 3), $sformatf("burst%0d", i));
    end
    m_cti = 3'b000;

    // Master abort: cyc dropped in the third ACCESS cycle, slave silent.
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h600; m_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_access", 64'({s_cyc_o, busy_o}), 64'b11);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    chk("abort_s_cyc", 64'({s_cyc_o, s_stb_o, busy_o}), 64'd0);
    chk("abort_no_resp", 64'({m_ack_o, m_err_o, timeout_o}), 64'd0);
    @(posedge clk); #1;
    chk("abort_still_quiet", 64'({m_ack_o, m_err_o, s_cyc_o}), 64'd0);

    // Asynchronous reset mid-access.
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h700; m_dat = 32'h1234; m_we = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_active", 64'(s_cyc_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, busy_o}), 64'd0);
    chk("async_reset_data", 64'({s_adr_o, m_dat_o}), 64'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    b = '{1'b0, 32'h0000_0500, 32'h0, 4'hF, 3'd0, 1, 1'b1, 1'b0, 32'h0BEE_F00D, 1, 1'b1, 1'b0, 1'b0, 32'h0BEE_F00D};
    run_beat(b, 1'b0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
